selfcomp_timing_monitor: RTL

//  Parametrised self-composition monitor for NUM_COPIES identical DUT copies

---
 rtl/selfcomp_timing_monitor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/selfcomp_timing_monitor.sv
// ============================================================================
// selfcomp_timing_monitor: completion-skew and timing-leak monitor for N DUT copies.
// Optional result compare: define SELFCOMP_RESULT_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module selfcomp_timing_monitor #(
  parameter int NUM_COPIES = 2,
  parameter int DATA_W     = 128,
  parameter int CNT_W      = 8,
  parameter int MAX_SKEW   = 64
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_COPIES-1:0]        copy_valid,
  input  logic [NUM_COPIES*DATA_W-1:0] copy_result,
  input  logic                         out_ready,
  input  logic                         clear,
  output logic                         busy,
  output logic                         report_valid,
  output logic [CNT_W-1:0]             last_skew,
  output logic                         timing_leak,
  output logic                         timeout,
  output logic                         result_mismatch,
  output logic [CNT_W-1:0]             txn_count,
  output logic [CNT_W-1:0]             leak_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(MAX_SKEW);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  state_e                state_q, state_d;
  logic [NUM_COPIES-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]      skew_q, skew_d;
  logic                  to_q, to_d;
  logic [CNT_W-1:0]      last_skew_q;
  logic                  leak_q, leak_d;
  logic                  tout_q, tout_d;
  logic [CNT_W-1:0]      txn_q, txn_d, txn_base;
  logic [CNT_W-1:0]      lcnt_q, lcnt_d, lcnt_base;
  logic [NUM_COPIES-1:0] hs, seen_all;
  logic                  rpt;

  assign hs       = copy_valid & {NUM_COPIES{out_ready}};
  assign seen_all = seen_q | hs;
  assign rpt      = (state_q == S_REPORT);

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    skew_d  = skew_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        seen_d = '0;
        skew_d = '0;
        to_d   = 1'b0;
        if (&hs) begin
          state_d = S_REPORT;
          seen_d  = hs;
        end else if (|hs) begin
          state_d = S_WAIT;
          seen_d  = hs;
          skew_d  = CNT_W'(1);
        end
      end
      S_WAIT: begin
        seen_d = seen_all;
        if (&seen_all) begin
          state_d = S_REPORT;
        end else if (skew_q == SKEW_LIMIT) begin
          state_d = S_REPORT;
          to_d    = 1'b1;
        end else begin
          skew_d = skew_q + CNT_W'(1);
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        seen_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear zeroes the base first so a report in the same cycle still lands.
  always_comb begin
    txn_base  = clear ? '0 : txn_q;
    lcnt_base = clear ? '0 : lcnt_q;
    leak_d    = (~clear & leak_q) | (rpt & (skew_q != '0));
    tout_d    = (~clear & tout_q) | (rpt & to_q);
    txn_d     = txn_base;
    lcnt_d    = lcnt_base;
    if (rpt && (txn_base != CNT_SAT)) txn_d = txn_base + CNT_W'(1);
    if (rpt && (skew_q != '0) && (lcnt_base != CNT_SAT)) lcnt_d = lcnt_base + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      seen_q      <= '0;
      skew_q      <= '0;
      to_q        <= 1'b0;
      last_skew_q <= '0;
      leak_q      <= 1'b0;
      tout_q      <= 1'b0;
      txn_q       <= '0;
      lcnt_q      <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      skew_q  <= skew_d;
      to_q    <= to_d;
      leak_q  <= leak_d;
      tout_q  <= tout_d;
      txn_q   <= txn_d;
      lcnt_q  <= lcnt_d;
      if ((state_d == S_REPORT) && !rpt) last_skew_q <= skew_d;
    end
  end

  assign busy         = (state_q == S_WAIT);
  assign report_valid = rpt;
  assign last_skew    = last_skew_q;
  assign timing_leak  = leak_q;
  assign timeout      = tout_q;
  assign txn_count    = txn_q;
  assign leak_count   = lcnt_q;

`ifdef SELFCOMP_RESULT_CHECK_EN
  logic [DATA_W-1:0] cap_q [NUM_COPIES];
  logic              diff;
  logic              mism_q, mism_d;

  for (genvar i = 0; i < NUM_COPIES; i++) begin : g_cap
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cap_q[i] <= '0;
      end else if (hs[i] && !seen_q[i] && !rpt) begin
        cap_q[i] <= copy_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only copies that actually completed take part; copy 0 is the reference.
  always_comb begin
    diff = 1'b0;
    for (int i = 1; i < NUM_COPIES; i++) begin
      if (seen_q[i] && seen_q[0] && (cap_q[i] != cap_q[0])) diff = 1'b1;
    end
    mism_d = (~clear & mism_q) | (rpt & diff);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mism_q <= 1'b0;
    else          mism_q <= mism_d;
  end

  assign result_mismatch = mism_q;
`else
  logic unused_result;
  assign unused_result   = ^copy_result;
  assign result_mismatch = 1'b0;
`endif

endmodule

`default_nettype wire
